i2c_scl_sequencer: RTL and testbench

I2C_SCL_SEQUENCER -- requirements
Module: i2c_scl_sequencer

---
 rtl/i2c_scl_pkg.sv | 57 +++++
 rtl/i2c_sync2.sv | 22 ++
 rtl/i2c_scl_sequencer.sv | 129 ++++++++++++
 tb/tb_i2c_scl_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_scl_pkg.sv
// Shared types for the I2C SCL/SDA bit-level sequencer.
package i2c_scl_pkg;

  localparam int unsigned CMD_W   = 2;
  localparam int unsigned STATE_W = 3;

  // Bit-level bus commands.
  typedef enum logic [CMD_W-1:0] {
    START     = 2'd0,
    STOP      = 2'd1,
    WRITE_BIT = 2'd2,
    READ_BIT  = 2'd3
  } cmd_e;

  // Sequencer states: idle plus four quarter-period phases.
  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    PH_A = 3'd1,
    PH_B = 3'd2,
    PH_C = 3'd3,
    PH_D = 3'd4
  } state_e;

  // Open-drain pull-down enables (1 pulls the line low).
  typedef struct packed {
    logic scl_oe;
    logic sda_oe;
  } drive_t;

  // Line drive for a given command and phase; idle releases both lines.
  function automatic drive_t phase_drive(cmd_e c, state_e st, logic wbit);
    drive_t d;
    d = '0;
    if (st != IDLE) begin
      case (c)
        START: begin
          d.scl_oe = (st == PH_D);
          d.sda_oe = (st == PH_C) || (st == PH_D);
        end
        STOP: begin
          d.scl_oe = (st == PH_A);
          d.sda_oe = (st != PH_D);
        end
        WRITE_BIT: begin
          d.scl_oe = (st == PH_A) || (st == PH_D);
          d.sda_oe = ~wbit;
        end
        default: begin
          d.scl_oe = (st == PH_A) || (st == PH_D);
          d.sda_oe = 1'b0;
        end
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchronizer for a raw bus level; resets to the released (high) level.
module i2c_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage resynchronization into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2c_scl_sequencer.sv
// Bit-level I2C sequencer: runs START/STOP/WRITE_BIT/READ_BIT as four timed
// quarter-period phases, honours slave clock stretching and samples SDA.
module i2c_scl_sequencer
  import i2c_scl_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CMD_W-1:0]      cmd,
  input  logic                  cmd_bit,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  scl_oe,
  output logic                  sda_oe,
  output logic                  rsp_valid,
  output logic                  rsp_bit,
  output logic                  busy,
  output logic                  stretch
);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  cmd_e                  cmd_q, cmd_d;
  logic                  bit_q, bit_d;
  logic                  cap_q, cap_d;
  logic                  rsp_valid_d, rsp_bit_d;
  drive_t                drv_d;
  logic                  scl_sync, sda_sync;
  logic                  hold_c, accept_c, is_bit_c;

  i2c_sync2 u_sync_scl (.clk(clk), .rst_n(rst_n), .d(scl_in), .q(scl_sync));
  i2c_sync2 u_sync_sda (.clk(clk), .rst_n(rst_n), .d(sda_in), .q(sda_sync));

  // Status decodes of registered state; a released SCL still seen low is a stretch.
  assign cmd_ready = (state_q == IDLE) && en;
  assign busy      = (state_q != IDLE);
  assign hold_c    = busy && !scl_oe && !scl_sync;
  assign stretch   = hold_c;
  assign accept_c  = cmd_valid && cmd_ready;
  assign is_bit_c  = (cmd_q == WRITE_BIT) || (cmd_q == READ_BIT);

  // Next-state, phase timer, SDA capture and registered-output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pre_d       = pre_q;
    cmd_d       = cmd_q;
    bit_d       = bit_q;
    cap_d       = cap_q;
    rsp_valid_d = 1'b0;
    rsp_bit_d   = rsp_bit;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = PH_A;
          cnt_d   = prescale;
          pre_d   = prescale;
          cmd_d   = cmd_e'(cmd);
          bit_d   = cmd_bit;
        end
      end
      default: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!hold_c) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - PRESCALE_W'(1);
          end else begin
            cnt_d = pre_q;
            case (state_q)
              PH_A: state_d = PH_B;
              PH_B: state_d = PH_C;
              PH_C: begin
                state_d = PH_D;
                if (is_bit_c) cap_d = sda_sync;
              end
              default: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (is_bit_c) begin
                  rsp_valid_d = 1'b1;
                  rsp_bit_d   = cap_q;
                end
              end
            endcase
          end
        end
      end
    endcase

    drv_d = phase_drive(cmd_d, state_d, bit_d);
  end

  // State, command latch and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pre_q     <= '0;
      cmd_q     <= START;
      bit_q     <= 1'b0;
      cap_q     <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_bit   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      cmd_q     <= cmd_d;
      bit_q     <= bit_d;
      cap_q     <= cap_d;
      scl_oe    <= drv_d.scl_oe;
      sda_oe    <= drv_d.sda_oe;
      rsp_valid <= rsp_valid_d;
      rsp_bit   <= rsp_bit_d;
    end
  end

endmodule

// File: tb/tb_i2c_scl_sequencer.sv
// Bench for i2c_scl_sequencer: phase-table reference model compared every
// cycle, directed timing scenarios with literal expectations, random traffic.
module tb_i2c_scl_sequencer;

  localparam int unsigned PW = 4;
  // Drive patterns per command, bit 3 = phase A ... bit 0 = phase D.
  localparam logic [3:0] SCL_PAT [4] = '{4'b0001, 4'b1000, 4'b1001, 4'b1001};
  localparam logic [3:0] SDA_PAT [4] = '{4'b0011, 4'b1110, 4'b0000, 4'b0000};
  localparam int O_BUSY = 0, O_SCL = 1, O_SDA = 2, O_RSP = 3, O_STR = 4, O_RSPB = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd = 2'd0;
  logic          cmd_bit = 1'b0;
  logic          scl_ext = 1'b1;
  logic          sda_ext = 1'b1;
  logic          scl_in, sda_in;
  logic          cmd_ready, scl_oe, sda_oe, rsp_valid, rsp_bit, busy, stretch;

  // SDA is wired-AND with our own pull-down; SCL only sees the slave.
  assign scl_in = scl_ext;
  assign sda_in = sda_ext & ~sda_oe;

  always #5 clk = ~clk;

  i2c_scl_sequencer #(.PRESCALE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .prescale(prescale),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .cmd_bit(cmd_bit),
    .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .rsp_valid(rsp_valid), .rsp_bit(rsp_bit), .busy(busy), .stretch(stretch)
  );

  // Reference model: phase number 0 (idle) or 1..4, cycles elapsed in phase.
  int         m_phase, m_el, m_cmd, m_p;
  logic       m_bit, m_cap;
  logic [1:0] sh_scl, sh_sda;
  logic       e_scl_oe, e_sda_oe, e_rsp_valid, e_rsp_bit, e_busy, e_stretch;
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic       obs_busy [100];
  logic       obs_scl  [100];
  logic       obs_sda  [100];
  logic       obs_rsp  [100];
  logic       obs_rspb [100];
  logic       obs_str  [100];

  function automatic logic drv_scl(int c, int ph);
    logic [3:0] p;
    logic [1:0] i;
    if (ph < 1 || ph > 4) return 1'b0;
    p = SCL_PAT[c[1:0]];
    i = 2'(4 - ph);
    return p[i];
  endfunction

  function automatic logic drv_sda(int c, int ph, logic b);
    logic [3:0] p;
    logic [1:0] i;
    if (ph < 1 || ph > 4) return 1'b0;
    if (c == 2) return ~b;
    p = SDA_PAT[c[1:0]];
    i = 2'(4 - ph);
    return p[i];
  endfunction

  task automatic model_reset();
    m_phase = 0; m_el = 0; m_cmd = 0; m_p = 0; m_bit = 1'b0; m_cap = 1'b0;
    sh_scl = 2'b11; sh_sda = 2'b11;
    e_scl_oe = 1'b0; e_sda_oe = 1'b0; e_rsp_valid = 1'b0; e_rsp_bit = 1'b0;
    e_busy = 1'b0; e_stretch = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs about to be sampled.
  task automatic model_step();
    logic s_scl, s_sda, hold, lvl_sda;
    s_scl   = sh_scl[1];
    s_sda   = sh_sda[1];
    lvl_sda = sda_ext & ~e_sda_oe;
    hold    = (m_phase != 0) && !drv_scl(m_cmd, m_phase) && !s_scl;
    e_rsp_valid = 1'b0;
    if (m_phase == 0) begin
      if (en && cmd_valid) begin
        m_cmd = int'(cmd); m_bit = cmd_bit; m_p = int'(prescale);
        m_phase = 1; m_el = 0;
      end
    end else if (!en) begin
      m_phase = 0;
    end else if (!hold) begin
      m_el++;
      if (m_el == m_p + 1) begin
        if (m_phase == 3 && m_cmd >= 2) m_cap = s_sda;
        if (m_phase == 4) begin
          m_phase = 0;
          if (m_cmd >= 2) begin
            e_rsp_valid = 1'b1;
            e_rsp_bit   = m_cap;
          end
        end else begin
          m_phase++;
          m_el = 0;
        end
      end
    end
    sh_scl = {sh_scl[0], scl_ext};
    sh_sda = {sh_sda[0], lvl_sda};
    e_busy    = (m_phase != 0);
    e_scl_oe  = drv_scl(m_cmd, m_phase);
    e_sda_oe  = drv_sda(m_cmd, m_phase, m_bit);
    e_stretch = e_busy && !e_scl_oe && !sh_scl[1];
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %b, want %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    chk("cmd_ready", cmd_ready, (m_phase == 0) && en);
    chk("busy", busy, e_busy);
    chk("scl_oe", scl_oe, e_scl_oe);
    chk("sda_oe", sda_oe, e_sda_oe);
    chk("rsp_valid", rsp_valid, e_rsp_valid);
    chk("rsp_bit", rsp_bit, e_rsp_bit);
    chk("stretch", stretch, e_stretch);
  endtask

  // One clock: model across the edge, compare at the falling edge, drive after.
  task automatic tick();
    if (rst_n) model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
    cyc++;
    if (cyc > 20000) begin
      $display("FAIL watchdog: got %0d cycles, want under 20000", cyc);
      $fatal(1, "watchdog expired");
    end
    #1;
  endtask

  task automatic record(input int k);
    obs_busy[k] = busy; obs_scl[k] = scl_oe; obs_sda[k] = sda_oe;
    obs_rsp[k] = rsp_valid; obs_rspb[k] = rsp_bit; obs_str[k] = stretch;
  endtask

  function automatic logic obs(input int sel, input int k);
    case (sel)
      O_BUSY:  return obs_busy[k];
      O_SCL:   return obs_scl[k];
      O_SDA:   return obs_sda[k];
      O_RSP:   return obs_rsp[k];
      O_STR:   return obs_str[k];
      default: return obs_rspb[k];
    endcase
  endfunction

  function automatic int count_obs(input int sel, input int n);
    int s = 0;
    for (int k = 0; k < n; k++) if (obs(sel, k) === 1'b1) s++;
    return s;
  endfunction

  function automatic int first_obs(input int sel, input int n);
    for (int k = 0; k < n; k++) if (obs(sel, k) === 1'b1) return k;
    return -1;
  endfunction

  task automatic wait_idle();
    int g = 0;
    cmd_valid = 1'b0; en = 1'b1; scl_ext = 1'b1; sda_ext = 1'b1;
    while (m_phase != 0 && g < 200) begin
      tick();
      g++;
    end
    chk("idle_reached", busy, 1'b0);
  endtask

  // Issue one command and record n samples; k counts edges after acceptance.
  task automatic run(input int c, input logic b, input int p, input int n,
                     input int low_from, input int low_to, input int drop_k);
    wait_idle();
    cmd = 2'(c); cmd_bit = b; prescale = PW'(p); cmd_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick();
      record(k);
      if (k == 0) begin
        cmd_valid = 1'b0;
        cmd = 2'($urandom_range(3));
        cmd_bit = ~b;
        prescale = PW'($urandom_range(15));
      end
      if (k == low_from) scl_ext = 1'b0;
      if (k == low_to) scl_ext = 1'b1;
      if (k == drop_k) en = 1'b0;
    end
    en = 1'b1; scl_ext = 1'b1;
  endtask

  initial begin
    int r;
    model_reset();
    repeat (3) tick();
    chk("reset_scl_oe", scl_oe, 1'b0);
    chk("reset_sda_oe", sda_oe, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    en = 1'b1;

    // START, prescale 4
    run(0, 1'b0, 4, 24, -1, -1, -1);
    chk_int("start_busy_cycles", count_obs(O_BUSY, 24), 20);
    chk_int("start_sda_rise", first_obs(O_SDA, 24), 10);
    chk_int("start_scl_rise", first_obs(O_SCL, 24), 15);
    chk_int("start_rsp_count", count_obs(O_RSP, 24), 0);

    // WRITE_BIT 0, prescale 4
    run(2, 1'b0, 4, 24, -1, -1, -1);
    chk_int("write_sda_cycles", count_obs(O_SDA, 24), 20);
    chk_int("write_rsp_count", count_obs(O_RSP, 24), 1);
    chk_int("write_rsp_cycle", first_obs(O_RSP, 24), 20);
    chk("write_rsp_bit", obs_rspb[20], 1'b0);

    // READ_BIT, prescale 2, SDA high
    run(3, 1'b0, 2, 16, -1, -1, -1);
    chk_int("read_rsp_cycle", first_obs(O_RSP, 16), 12);
    chk("read_rsp_bit", obs_rspb[12], 1'b1);

    // READ_BIT, prescale 4, slave holds SCL low for 7 cycles in PH_B
    run(3, 1'b0, 4, 32, 4, 11, -1);
    chk_int("stretch_cycles", count_obs(O_STR, 32), 7);
    chk_int("stretch_rsp_cycle", first_obs(O_RSP, 32), 27);

    // en dropped mid WRITE_BIT
    run(2, 1'b0, 4, 12, -1, -1, 5);
    chk("abort_sda_before", obs_sda[5], 1'b1);
    chk("abort_busy", obs_busy[6], 1'b0);
    chk("abort_scl_oe", obs_scl[6], 1'b0);
    chk("abort_sda_oe", obs_sda[6], 1'b0);
    chk_int("abort_rsp_count", count_obs(O_RSP, 12), 0);

    // prescale 0, STOP then START back to back with cmd_valid held
    wait_idle();
    prescale = '0; cmd = 2'd1; cmd_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      record(k);
      if (k == 0) cmd = 2'd0;
      if (k == 5) cmd_valid = 1'b0;
    end
    chk_int("b2b_busy_cycles", count_obs(O_BUSY, 10), 8);
    chk("b2b_gap_idle", obs_busy[4], 1'b0);
    chk("b2b_second_busy", obs_busy[5], 1'b1);
    chk("b2b_end_idle", obs_busy[9], 1'b0);
    chk("b2b_stop_a_scl", obs_scl[0], 1'b1);
    chk("b2b_stop_d_sda", obs_sda[3], 1'b0);
    chk("b2b_start_a_sda", obs_sda[5], 1'b0);
    chk("b2b_start_d_scl", obs_scl[8], 1'b1);

    // Maximum prescale does not wrap the counter
    run(3, 1'b0, 15, 70, -1, -1, -1);
    chk_int("maxpre_busy_cycles", count_obs(O_BUSY, 70), 64);
    chk_int("maxpre_rsp_cycle", first_obs(O_RSP, 70), 64);

    // Reset in the middle of a WRITE_BIT
    wait_idle();
    cmd = 2'd2; cmd_bit = 1'b0; prescale = PW'(3); cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_scl_oe", scl_oe, 1'b0);
    chk("midrst_sda_oe", sda_oe, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    r = 0;
    repeat (20) begin
      tick();
      if (rsp_valid === 1'b1) r++;
    end
    chk_int("midrst_no_rsp", r, 0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      en        = ($urandom_range(99) < 97);
      cmd_valid = 1'($urandom_range(1));
      cmd       = 2'($urandom_range(3));
      cmd_bit   = 1'($urandom_range(1));
      prescale  = ($urandom_range(7) == 0) ? PW'($urandom_range(15)) : PW'($urandom_range(3));
      scl_ext   = ($urandom_range(9) != 0);
      sda_ext   = 1'($urandom_range(1));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
